// File: rtl/uart_tx_engine.sv
// ============================================================================
//  Module      : uart_tx_engine
//  Description : UART transmit serializer fed from a registered-output TX FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_engine #(
  parameter int DATA_WD = 8,
  parameter int DIV_WD  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tx_en,
  input  logic [DIV_WD-1:0] baud_div,
  input  logic              parity_en,
  input  logic              parity_odd,
  input  logic              two_stop,
  input  logic              fifo_empty,
  input  logic [DATA_WD-1:0] fifo_rd_data,
  output logic              fifo_rd_en,
  output logic              tx,
  output logic              busy,
  output logic              frame_done
);

  localparam int                c_BCW  = $clog2(DATA_WD + 1);
  localparam logic [c_BCW-1:0]  c_LAST = c_BCW'(DATA_WD - 1);
  localparam logic [DIV_WD-1:0] c_ONE  = DIV_WD'(1);
  localparam logic [DIV_WD-1:0] c_TWO  = DIV_WD'(2);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_REQ    = 3'd1,
    S_LOAD   = 3'd2,
    S_START  = 3'd3,
    S_DATA   = 3'd4,
    S_PARITY = 3'd5,
    S_STOP   = 3'd6
  } state_t;

  state_t              r_state;
  logic                r_tx;
  logic                r_rd_en;
  logic                r_busy;
  logic                r_done;
  logic [DATA_WD-1:0]  r_shift;
  logic                r_par;
  logic [DIV_WD-1:0]   r_n;
  logic                r_par_en;
  logic                r_two_stop;
  logic                r_stop2;
  logic [DIV_WD-1:0]   r_timer;
  logic [c_BCW-1:0]    r_bitcnt;

  logic                w_bit_end;
  logic                w_start_ok;
  logic [DIV_WD-1:0]   w_n_in;

  // r_n is clamped to >= 2, so r_n - 1 never underflows
  assign w_bit_end  = (r_timer == (r_n - c_ONE));
  assign w_start_ok = tx_en && !fifo_empty;
  assign w_n_in     = (baud_div < c_TWO) ? c_TWO : baud_div;

  assign fifo_rd_en = r_rd_en;
  assign tx         = r_tx;
  assign busy       = r_busy;
  assign frame_done = r_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_tx       <= 1'b1;
      r_rd_en    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_shift    <= '0;
      r_par      <= 1'b0;
      r_n        <= c_TWO;
      r_par_en   <= 1'b0;
      r_two_stop <= 1'b0;
      r_stop2    <= 1'b0;
      r_timer    <= '0;
      r_bitcnt   <= '0;
    end else begin
      r_rd_en <= 1'b0;
      r_done  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_start_ok) begin
            r_rd_en <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= S_REQ;
          end
        end
        S_REQ: begin
          r_state <= S_LOAD;
        end
        S_LOAD: begin
          // Whole frame configuration is frozen here
          r_shift    <= fifo_rd_data;
          r_par      <= (^fifo_rd_data) ^ parity_odd;
          r_n        <= w_n_in;
          r_par_en   <= parity_en;
          r_two_stop <= two_stop;
          r_stop2    <= 1'b0;
          r_timer    <= '0;
          r_bitcnt   <= '0;
          r_tx       <= 1'b0;
          r_state    <= S_START;
        end
        S_START: begin
          if (w_bit_end) begin
            r_timer <= '0;
            r_tx    <= r_shift[0];
            r_state <= S_DATA;
          end else begin
            r_timer <= r_timer + c_ONE;
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            r_timer <= '0;
            r_shift <= {1'b0, r_shift[DATA_WD-1:1]};
            if (r_bitcnt == c_LAST) begin
              if (r_par_en) begin
                r_tx    <= r_par;
                r_state <= S_PARITY;
              end else begin
                r_tx    <= 1'b1;
                r_state <= S_STOP;
              end
            end else begin
              r_bitcnt <= r_bitcnt + 1'b1;
              r_tx     <= r_shift[1];
            end
          end else begin
            r_timer <= r_timer + c_ONE;
          end
        end
        S_PARITY: begin
          if (w_bit_end) begin
            r_timer <= '0;
            r_tx    <= 1'b1;
            r_state <= S_STOP;
          end else begin
            r_timer <= r_timer + c_ONE;
          end
        end
        S_STOP: begin
          if (w_bit_end) begin
            r_timer <= '0;
            if (r_two_stop && !r_stop2) begin
              r_stop2 <= 1'b1;
            end else begin
              r_stop2 <= 1'b0;
              r_done  <= 1'b1;
              if (w_start_ok) begin
                r_rd_en <= 1'b1;
                r_state <= S_REQ;
              end else begin
                r_busy  <= 1'b0;
                r_state <= S_IDLE;
              end
            end
          end else begin
            r_timer <= r_timer + c_ONE;
          end
        end
        default: begin
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/uart_tx_engine.md
Name: uart_tx_engine

Overview:
- Transmit serializer placed directly downstream of the TX FIFO in the UART IP.
- Pops one word at a time through the FIFO read port. The FIFO's `rd_data` is registered, so data is valid the cycle after the read is sampled.
- Drives the serial line as start bit, `data_wd` data bits (LSB first), an optional parity bit, and 1 or 2 stop bits.
- Bit timing comes from an internal divider programmed at run time.

Parameters:
- data_wd, 8, data bits per frame (legal 5..8); must equal the TX FIFO data width
- div_wd, 16, width of the baud divisor input

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous active-high reset
- tx_en  input  1  enables starting new frames; a frame in progress always completes
- baud_div  input  div_wd  clocks per bit period; values below 2 are treated as 2
- parity_en  input  1  1 = insert parity bit
- parity_odd  input  1  1 = odd parity, 0 = even
- two_stop  input  1  1 = two stop bits, 0 = one
- fifo_empty  input  1  TX FIFO empty flag
- fifo_rd_data  input  data_wd  TX FIFO registered read data
- fifo_rd_en  output  1  registered one-cycle read strobe to the TX FIFO
- tx  output  1  serial line, idles high
- busy  output  1  high from REQ through end of last stop bit
- frame_done  output  1  one-cycle pulse after the last stop bit period

Behaviour:
- Reset (sampled on a clk edge): state=IDLE, tx=1, fifo_rd_en=0, busy=0, frame_done=0, all counters and the shift register cleared. Reset asserted mid-frame aborts the frame; tx is high at the following edge and no further FIFO read is issued.
- All outputs are registered.
- State machine: IDLE, REQ, LOAD, START, DATA, PARITY, STOP.
- IDLE: if tx_en && !fifo_empty, set fifo_rd_en=1 and go to REQ; otherwise stay.
- REQ (1 cycle): fifo_rd_en=0. The FIFO samples the strobe on this edge and updates rd_data. Go to LOAD.
- LOAD (1 cycle): capture fifo_rd_data into the shift register; latch baud_div, parity_en, parity_odd and two_stop; clear the bit-timer; go to START.
- Config inputs changing mid-frame have no effect until the next LOAD.
- Exactly one fifo_rd_en pulse is issued per frame. A pulse is never issued while fifo_empty=1.
- Bit timer: counts 0..N-1, where N = max(latched baud_div, 2). Each bit holds tx for exactly N clocks.
- START: tx=0 for N clocks, then DATA.
- DATA: tx = shift register bit 0; shift right at the end of each bit. After data_wd bits, go to PARITY if parity_en, else STOP.
- PARITY: tx = XOR of the data bits, inverted if parity_odd. Lasts N clocks, then STOP.
- STOP: tx=1 for N clocks, or 2N if two_stop.
- At the end of STOP: pulse frame_done for one cycle. If tx_en && !fifo_empty, assert fifo_rd_en and go straight to REQ; else go to IDLE.
- Minimum inter-frame line-high gap is 2 clocks (REQ + LOAD) beyond the stop bits.
- busy: 1 in REQ, LOAD, START, DATA, PARITY and STOP; 0 in IDLE.
- tx_en dropping mid-frame: the current frame finishes normally and no new read is issued.
- fifo_empty rising mid-frame has no effect on the current frame.
- baud_div=0 or 1 behaves identically to 2.
- Maximum baud_div (all ones) must not overflow the bit-timer; the counter is div_wd bits.
- Frame length in clocks: N × (1 + data_wd + parity_en + 1 + two_stop).

Test Plan:
- Reset then idle: tx_en=1, fifo_empty=1 for 100 clocks -> tx=1, fifo_rd_en never asserted, busy=0.
- Single frame, 8N1: baud_div=4, FIFO holds 0xA5 -> one fifo_rd_en pulse; tx low 2 clocks later for 4 clocks; data bits 1,0,1,0,0,1,0,1 at 4 clocks each; stop high 4 clocks; frame_done pulse; 40 clocks from START to frame_done.
- Parity and two stop bits: baud_div=3, parity_en=1, parity_odd=0, two_stop=1, data 0x07 -> parity bit=1, stop high 6 clocks. Repeat with parity_odd=1 -> parity bit=0.
- Back-to-back frames: FIFO holds 0x01, 0x02, 0x03, tx_en=1 -> 3 read pulses, 3 frame_done pulses; line high exactly N+2 clocks between frames (1 stop); FIFO ends empty; engine returns to IDLE.
- Mid-frame events: drop tx_en during DATA of frame 1 with 2 words queued -> frame 1 completes, no second read. Change baud_div from 4 to 8 mid-frame -> bit width stays 4 until the next LOAD.
- Reset mid-frame: assert rst during DATA bit 3 -> tx=1 and busy=0 at the next edge. After release with data pending, a fresh frame starts with a new start bit.
